pwm_multi_channel: RTL and testbench
====================================

# pwm_multi_channel

Parametrised multi-channel PWM generator. NUM_CH outputs share one period counter, and each channel has its own duty cycle. Duty and period writes go to shadow registers and are committed glitch-free at the period boundary. Sits between the processor register interface and the motor/LED output pins. Optional center-aligned (up/down) counting mode.

## Interface
- NUM_CH, default 4: number of PWM channels, 1–16.
- CNT_WIDTH, default 16: width of the counter, period and duty values.
- DEFAULT_PERIOD, default 255: reset value of the period shadow and active registers.

- clk  in  1: clock.
- reset  in  1: synchronous, active-low.
- enable  in  1: run counter; low = hold counter and outputs idle.
- mode  in  1: 0 = edge-aligned, 1 = center-aligned. Honoured only with PWM_CENTER_ALIGN_EN.
- period_wr  in  1: write `period_in` to the period shadow.
- period_in  in  CNT_WIDTH: new period value (terminal count).
- duty_wr  in  1: write `duty_in` to the duty shadow of channel `duty_ch`.
- duty_ch  in  $clog2(NUM_CH) (min 1): channel index for the duty write.
- duty_in  in  CNT_WIDTH: new duty value (high-count).
- pwm_out  out  NUM_CH: PWM outputs, registered.
- period_start  out  1: one-cycle pulse aligned with `pwm_out` for count 0, registered.

## Operation
- Reset (reset==0 at posedge):
  - cnt=0, dir=up, pwm_out=0, period_start=0.
  - All duty shadow and active registers = 0.
  - Period shadow and active registers = DEFAULT_PERIOD.
- Shadow writes:
  - `period_wr` loads the period shadow.
  - `duty_wr` loads duty shadow[duty_ch].
  - Both may occur in the same cycle.
  - A `duty_ch` value ≥ NUM_CH is ignored.
- Commit: active ← shadow for the period and all duties, atomically, on the edge where cnt returns to 0.
  - A write in the commit cycle is not included in that commit; it lands in the shadow and commits at the next boundary.
- Edge-aligned mode (mode=0):
  - If cnt ≥ period_act: cnt←0 and commit. Else cnt←cnt+1.
  - Period length is period_act+1 cycles.
- Center-aligned mode (mode=1):
  - Up phase: if cnt ≥ period_act, dir←down and cnt←cnt−1.
  - Down phase: if cnt ≤ 1, cnt←0, dir←up and commit. Else cnt←cnt−1.
  - Period length is 2·period_act cycles, with sequence 0,1..P,P−1..1.
  - If period_act==0, behave as edge-aligned.
- Output logic: pwm_out[i] ← (cnt < duty_act[i]); period_start ← (cnt==0).
  - duty_act=0 gives constant low.
  - duty_act > period_act gives constant high. There is no wrap or glitch.
- Period of 0 (edge-aligned): cnt stays 0 and commits every cycle. pwm_out[i]=1 iff duty_act[i] ≥ 1.
- enable=0:
  - cnt←0, dir←up, pwm_out←0, period_start←0.
  - Commit occurs every cycle, so shadows are reflected immediately when re-enabled.
- Mode change takes effect only at a boundary; the mode is sampled together with the commit.
- Reset mid-period: outputs are 0 on the next cycle and all shadow writes are discarded.

## Timing
- `pwm_out` lags cnt by exactly one cycle; all outputs are registered.
- First rising edge after enable 0→1 with duty>0: cnt=0 in the first enabled cycle, and pwm_out=1 one cycle later. period_start is high in that same cycle.
- Write-to-effect latency: from the write to the next boundary plus 1 cycle.
  - Maximum is period_act+2 cycles (edge-aligned) or 2·period_act+1 cycles (center-aligned).
- Single clock domain. No combinational input-to-output paths.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined: the `mode` input, the direction register and the center-aligned logic are compiled in.
- Not defined: the `mode` port still exists but is ignored. The counter is always edge-aligned and no direction register is built.

## Test plan
- Reset, then period=9, duty[0]=3, enable=1 → pwm_out[0] high 3 cycles, low 7, repeating every 10 cycles. period_start pulses every 10 cycles, coincident with the first high cycle.
- duty[1]=0 and duty[2]=10 with period=9 → pwm_out[1] constantly 0 and pwm_out[2] constantly 1, with no glitch at the wrap.
- Mid-period (cnt=4) write duty[0]=7 → the current period keeps 3 high cycles and the next period has 7. A write exactly in the commit cycle appears one period later.
- duty_wr with duty_ch=NUM_CH → no channel changes. Simultaneous period_wr=4 and duty_wr → both commit at the same boundary; the new period is 5 cycles.
- With PWM_CENTER_ALIGN_EN: mode=1, period=4, duty=2 → cnt sequence 0,1,2,3,4,3,2,1 and pwm_out pattern 1,1,0,0,0,0,0,1 (lagged 1 cycle), period 8 cycles.
- reset=0 asserted at cnt=5 → next cycle pwm_out=0 and cnt=0. After release, period=DEFAULT_PERIOD and all duties=0.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM, shared period counter, shadowed duty/period
// Optional up/down counting compiled in with PWM_CENTER_ALIGN_EN.
module pwm_multi_channel #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int DEFAULT_PERIOD = 255,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 period_wr,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 duty_wr,
  input  logic [CH_W-1:0]      duty_ch,
  input  logic [CNT_WIDTH-1:0] duty_in,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_start
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] period_sh, period_act;
  logic [CNT_WIDTH-1:0] duty_sh  [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_act [NUM_CH];
  logic                 commit;

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_down, dir_down_nxt, mode_act;

  always_comb begin
    cnt_nxt      = cnt;
    dir_down_nxt = dir_down;
    commit       = 1'b0;
    if (!enable) begin
      cnt_nxt      = '0;
      dir_down_nxt = 1'b0;
      commit       = 1'b1;
    end else if (!mode_act || period_act == '0) begin
      dir_down_nxt = 1'b0;
      if (cnt >= period_act) begin
        cnt_nxt = '0;
        commit  = 1'b1;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end else if (!dir_down) begin
      if (cnt >= period_act) begin
        // A period of 1 has no down slope: wrap straight to 0 so the period stays 2 cycles.
        if (cnt <= ONE) begin
          cnt_nxt = '0;
          commit  = 1'b1;
        end else begin
          dir_down_nxt = 1'b1;
          cnt_nxt      = cnt - ONE;
        end
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end else begin
      if (cnt <= ONE) begin
        cnt_nxt      = '0;
        dir_down_nxt = 1'b0;
        commit       = 1'b1;
      end else begin
        cnt_nxt = cnt - ONE;
      end
    end
  end

  // Mode is latched with the commit so a change only takes effect at a boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_down <= 1'b0;
      mode_act <= 1'b0;
    end else begin
      dir_down <= dir_down_nxt;
      if (commit) mode_act <= mode;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    cnt_nxt = cnt + ONE;
    commit  = 1'b0;
    if (!enable || cnt >= period_act) begin
      cnt_nxt = '0;
      commit  = 1'b1;
    end
  end
`endif

  // Shadow writes and commit share one edge; nonblocking order keeps a commit-cycle write out of that commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      period_sh    <= CNT_WIDTH'(DEFAULT_PERIOD);
      period_act   <= CNT_WIDTH'(DEFAULT_PERIOD);
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      cnt <= cnt_nxt;
      if (period_wr) period_sh <= period_in;
      for (int i = 0; i < NUM_CH; i++) begin
        if (duty_wr && duty_ch == CH_W'(i)) duty_sh[i] <= duty_in;
      end
      if (commit) begin
        period_act <= period_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end
      for (int i = 0; i < NUM_CH; i++) pwm_out[i] <= enable && (cnt < duty_act[i]);
      period_start <= enable && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel
module tb_pwm_multi_channel;

  localparam int NUM_CH         = 3;
  localparam int CNT_WIDTH      = 16;
  localparam int DEFAULT_PERIOD = 20;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 mode;
  logic                 period_wr;
  logic [CNT_WIDTH-1:0] period_in;
  logic                 duty_wr;
  logic [1:0]           duty_ch;
  logic [CNT_WIDTH-1:0] duty_in;
  logic [NUM_CH-1:0]    pwm_out;
  logic                 period_start;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pwm_multi_channel #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .period_wr(period_wr), .period_in(period_in),
    .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  // Expected {period_start, pwm_out[2:0]} for an edge-aligned run of n outputs.
  task automatic push_edge(input string tag, input int k0, input int n, input int len,
                           input int d0, input int d1, input int d2);
    for (int k = k0; k < k0 + n; k++) begin
      int ph;
      ph = k % len;
      push(tag, {ph == 0, ph < d2, ph < d1, ph < d0});
    end
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check(e.tag, 32'({period_start, pwm_out}), 32'(e.val));
      end
    end
  endtask

  task automatic write_duty(input logic [1:0] ch, input int v);
    duty_wr = 1'b1;
    duty_ch = ch;
    duty_in = CNT_WIDTH'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 1'b0;
    period_wr = 1'b0; period_in = '0;
    duty_wr = 1'b0; duty_ch = '0; duty_in = '0;

    for (int i = 0; i < 3; i++) push("reset", 4'b0000);
    run(3);
    reset = 1'b1;

    // Edge-aligned: period 9, duty0=3, duty1=0, duty2=10; mid-period and commit-cycle writes.
    period_wr = 1'b1; period_in = 16'd9;
    write_duty(2'd0, 3);
    push("cfg", 4'b0000); run(1);
    period_wr = 1'b0;
    write_duty(2'd2, 10);
    push("cfg", 4'b0000); run(1);
    duty_wr = 1'b0;
    push("cfg_commit", 4'b0000); run(1);
    enable = 1'b1;
    push_edge("s1_duty3", 0, 10, 10, 3, 0, 10);
    push_edge("s1_duty7", 10, 20, 10, 7, 0, 10);
    push_edge("s1_duty5", 30, 10, 10, 5, 0, 10);
    run(4);
    write_duty(2'd0, 7);
    run(1);
    duty_wr = 1'b0;
    run(14);
    write_duty(2'd0, 5);
    run(1);
    duty_wr = 1'b0;
    run(20);

    // Invalid channel ignored; simultaneous period and duty writes commit together.
    push_edge("s2_old", 40, 10, 10, 5, 0, 10);
    push_edge("s2_new", 0, 15, 5, 2, 0, 10);
    write_duty(2'd3, 1);
    run(1);
    write_duty(2'd0, 2);
    period_wr = 1'b1; period_in = 16'd4;
    run(1);
    duty_wr = 1'b0; period_wr = 1'b0;
    run(8);
    run(15);

`ifdef PWM_CENTER_ALIGN_EN
    enable = 1'b0; mode = 1'b1;
    push("c_idle", 4'b0000); push("c_idle", 4'b0000);
    run(2);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] pat;
      pat = 8'b1000_0011;
      push("center", {k % 8 == 0, 1'b1, 1'b0, pat[k % 8]});
    end
    run(16);
`endif

    // Reset mid-period at cnt=5 discards pending shadow writes.
    enable = 1'b0; mode = 1'b0;
    period_wr = 1'b1; period_in = 16'd9;
    push("idle", 4'b0000); run(1);
    period_wr = 1'b0;
    push("idle", 4'b0000); run(1);
    enable = 1'b1;
    push_edge("s4_pre", 0, 5, 10, 2, 0, 10);
    run(5);
    reset = 1'b0;
    period_wr = 1'b1; period_in = 16'd3;
    write_duty(2'd0, 6);
    push("mid_reset", 4'b0000); run(1);
    reset = 1'b1; period_wr = 1'b0; duty_wr = 1'b0;
    push_edge("s4_default", 0, 45, DEFAULT_PERIOD + 1, 0, 0, 0);
    run(45);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
